// File: rtl/msk_sbox_bt_ctrl_if.sv
//==============================================================================
// Module   : msk_sbox_bt_ctrl_if
// Brief    : Request/status and randomness bundle between the BT controller and its user.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface msk_sbox_bt_ctrl_if #(
  parameter int D = 2
);
  logic [31:0]        seed;
  logic               seed_ld;
  logic               start;
  logic               abort;
  logic               ready;
  logic               busy;
  logic               done;
  logic [11:0]        ctrl;
  logic [3:0]         en;
  logic [D*(D-1)-1:0] rnd;
  logic [3:0]         rnd_BT;
  logic               clear;

  modport master (
    output seed, seed_ld, start, abort,
    input  ready, busy, done, ctrl, en, rnd, rnd_BT, clear
  );

  modport slave (
    input  seed, seed_ld, start, abort,
    output ready, busy, done, ctrl, en, rnd, rnd_BT, clear
  );
endinterface

`default_nettype wire

// File: rtl/msk_sbox_bt_ctrl.sv
//==============================================================================
// Module   : msk_sbox_bt_ctrl
// Brief    : Masked SKINNY S-box sequencer: 6-cycle schedule, LFSR randomness,
//            Borrowed-Time clear pulse. Option macro: BT_CLEAR_ON_DONE_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module msk_sbox_bt_ctrl #(
  parameter int D = 2
) (
  input wire                clk,
  input wire                rst_n,
  msk_sbox_bt_ctrl_if.slave bus
);
  localparam int          RW        = D * (D - 1);
  localparam logic [3:0]  FILL_MAX  = 4'd10;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_CLR   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    cyc_q, cyc_d;
  logic [3:0]    fill_q, fill_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          clear_q, clear_d;
  logic [11:0]   ctrl_q, ctrl_d;
  logic [3:0]    en_q, en_d;
  logic [RW-1:0] rnd_w;

  function automatic logic [11:0] ctrl_for(input logic [2:0] c);
    logic [11:0] v;
    case (c)
      3'd0:    v = 12'hA50;
      3'd1:    v = 12'h5A3;
      3'd2:    v = 12'h0F6;
      3'd3:    v = 12'h3C9;
      3'd4:    v = 12'hC3C;
      default: v = 12'h000;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] en_for(input logic [2:0] c);
    logic [3:0] v;
    case (c)
      3'd2:    v = 4'b0001;
      3'd3:    v = 4'b0010;
      3'd4:    v = 4'b0100;
      3'd5:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  // Control outputs lag the schedule counter by one cycle: they are
  // registered from the current state, while busy/ready follow the next state.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    clear_d = 1'b0;
    ctrl_d  = 12'h000;
    en_d    = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (bus.abort) begin
          state_d = S_CLR;
        end else if (bus.start && ready_q) begin
          state_d = S_RUN;
          cyc_d   = 3'd0;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_CLR;
        end else begin
          ctrl_d = ctrl_for(cyc_q);
          en_d   = en_for(cyc_q);
          if (cyc_q == 3'd5) begin
            state_d = S_FLUSH;
          end else begin
            cyc_d = cyc_q + 3'd1;
          end
        end
      end
      S_FLUSH: begin
        if (bus.abort) begin
          state_d = S_CLR;
        end else begin
          done_d = 1'b1;
`ifdef BT_CLEAR_ON_DONE_EN
          state_d = S_CLR;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_CLR: begin
        if (fill_q == FILL_MAX) begin
          clear_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The S-box restarts its unused-mask accounting in the cycle it sees clear.
  always_comb begin
    if (clear_q) begin
      fill_d = 4'd0;
    end else if (fill_q == FILL_MAX) begin
      fill_d = FILL_MAX;
    end else begin
      fill_d = fill_q + 4'd1;
    end
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_q == S_IDLE) && (state_d == S_IDLE) && (fill_d == FILL_MAX);
  end

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    if (bus.seed_ld && (state_q != S_RUN)) begin
      lfsr_d = (bus.seed == 32'd0) ? 32'd1 : bus.seed;
    end
  end

  for (genvar i = 0; i < RW; i++) begin : g_rnd
    assign rnd_w[i] = lfsr_q[4 + (i % 28)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= 3'd0;
      fill_q  <= 4'd0;
      lfsr_q  <= 32'd1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      ctrl_q  <= 12'h000;
      en_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      fill_q  <= fill_d;
      lfsr_q  <= lfsr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clear_q <= clear_d;
      ctrl_q  <= ctrl_d;
      en_q    <= en_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ctrl   = ctrl_q;
  assign bus.en     = en_q;
  assign bus.clear  = clear_q;
  assign bus.rnd_BT = lfsr_q[3:0];
  assign bus.rnd    = rnd_w;

endmodule

`default_nettype wire
